// File: rtl/prewitt_stream_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : prewitt_stream_filter
//  Description : Streaming 3x3 Prewitt edge detector for raster-order pixels.
//                Two line buffers hold the previous rows. The mode is latched
//                per frame and selects |Gx|, |Gy|, |Gx|+|Gy| or max(|Gx|,|Gy|).
//                valid/ready handshakes are used on both the input and output.
//  Revision    : 1.0  initial release
// ============================================================================
module prewitt_stream_filter #(
    parameter int PIX_W = 8,
    parameter int COLS  = 247,
    parameter int ROWS  = 242
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last,
    output logic             busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int SW    = PIX_W + 2;   // unsigned sum of three pixels
    localparam int GW    = PIX_W + 3;   // signed gradient / magnitude width

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FILL  = 2'd1;
    localparam logic [1:0] c_S_RUN   = 2'd2;
    localparam logic [1:0] c_S_FLUSH = 2'd3;

    localparam logic [1:0] c_MODE_GX  = 2'd0;
    localparam logic [1:0] c_MODE_GY  = 2'd1;
    localparam logic [1:0] c_MODE_SUM = 2'd2;

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] c_ROW_ONE  = ROW_W'(1);

    // Control state
    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [COL_W-1:0] r_in_col;
    logic [ROW_W-1:0] r_in_row;
    logic [COL_W-1:0] r_cen_col;
    logic [ROW_W-1:0] r_cen_row;

    // Line buffers: r_lb_a holds the row above the incoming pixel, r_lb_b the row above that
    logic [PIX_W-1:0] r_lb_a [COLS];
    logic [PIX_W-1:0] r_lb_b [COLS];

    // Window columns: l = two columns back, c = one column back (top/middle/bottom)
    logic [PIX_W-1:0] r_l_t, r_l_m, r_l_b;
    logic [PIX_W-1:0] r_c_t, r_c_m, r_c_b;
    logic [PIX_W-1:0] w_n_t, w_n_m, w_n_b;

    // Output register
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pixel;
    logic             r_out_last;

    // Handshake and datapath wires
    logic             w_out_free;
    logic             w_in_beat;
    logic             w_in_last;
    logic             w_fill_done;
    logic             w_load;
    logic             w_border;
    logic             w_cen_last;
    logic [SW-1:0]    w_sum_left, w_sum_right, w_sum_top, w_sum_bot;
    logic signed [GW-1:0] w_gx, w_gy;
    logic [GW-1:0]    w_abs_gx, w_abs_gy, w_mag;
    logic [PIX_W-1:0] w_sat, w_result;

    assign w_out_free  = !r_out_valid || out_ready;
    assign in_ready    = (r_state != c_S_FLUSH) && w_out_free;
    assign w_in_beat   = in_valid && in_ready;
    assign w_in_last   = (r_in_row == c_ROW_LAST) && (r_in_col == c_COL_LAST);
    // Input index COLS is row 1, col 0: the window pipeline is primed after it
    assign w_fill_done = (r_in_row == c_ROW_ONE) && (r_in_col == '0);

    // Newest window column: two rows from the line buffers plus the live pixel
    assign w_n_t = r_lb_b[r_in_col];
    assign w_n_m = r_lb_a[r_in_col];
    assign w_n_b = in_pixel;

    assign w_sum_left  = {2'b00, r_l_t} + {2'b00, r_l_m} + {2'b00, r_l_b};
    assign w_sum_right = {2'b00, w_n_t} + {2'b00, w_n_m} + {2'b00, w_n_b};
    assign w_sum_top   = {2'b00, r_l_t} + {2'b00, r_c_t} + {2'b00, w_n_t};
    assign w_sum_bot   = {2'b00, r_l_b} + {2'b00, r_c_b} + {2'b00, w_n_b};

    assign w_gx = $signed({1'b0, w_sum_left}) - $signed({1'b0, w_sum_right});
    assign w_gy = $signed({1'b0, w_sum_top})  - $signed({1'b0, w_sum_bot});

    // Magnitude selection; |Gx|+|Gy| peaks at 6*(2^PIX_W-1) which still fits GW bits
    always_comb begin
        w_abs_gx = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_abs_gy = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
        case (r_mode)
            c_MODE_GX:  w_mag = w_abs_gx;
            c_MODE_GY:  w_mag = w_abs_gy;
            c_MODE_SUM: w_mag = w_abs_gx + w_abs_gy;
            default:    w_mag = (w_abs_gx >= w_abs_gy) ? w_abs_gx : w_abs_gy;
        endcase
        w_sat = (|w_mag[GW-1:PIX_W]) ? {PIX_W{1'b1}} : w_mag[PIX_W-1:0];
    end

    // Border centres carry stale or wrapped columns/rows, so they are forced to zero
    assign w_border   = (r_cen_row == '0) || (r_cen_row == c_ROW_LAST) ||
                        (r_cen_col == '0) || (r_cen_col == c_COL_LAST);
    assign w_cen_last = (r_cen_row == c_ROW_LAST) && (r_cen_col == c_COL_LAST);
    assign w_result   = w_border ? '0 : w_sat;

    // In RUN every accepted pixel yields one result; in FLUSH results drain as the sink frees up
    assign w_load = ((r_state == c_S_RUN) && w_in_beat) ||
                    ((r_state == c_S_FLUSH) && w_out_free && !(r_out_valid && r_out_last));

    // Line buffers shift down one row per accepted pixel (no reset: written before use)
    always_ff @(posedge clk) begin
        if (w_in_beat) begin
            r_lb_a[r_in_col] <= in_pixel;
            r_lb_b[r_in_col] <= r_lb_a[r_in_col];
        end
    end

    // Frame FSM, mode latch, input position counters and window column shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_mode   <= 2'd0;
            r_in_col <= '0;
            r_in_row <= '0;
            r_l_t    <= '0;
            r_l_m    <= '0;
            r_l_b    <= '0;
            r_c_t    <= '0;
            r_c_m    <= '0;
            r_c_b    <= '0;
        end else begin
            if (w_in_beat) begin
                r_l_t <= r_c_t;
                r_l_m <= r_c_m;
                r_l_b <= r_c_b;
                r_c_t <= w_n_t;
                r_c_m <= w_n_m;
                r_c_b <= w_n_b;
                if (r_in_col == c_COL_LAST) begin
                    r_in_col <= '0;
                    r_in_row <= (r_in_row == c_ROW_LAST) ? '0 : r_in_row + c_ROW_ONE;
                end else begin
                    r_in_col <= r_in_col + c_COL_ONE;
                end
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_in_beat) begin
                        r_mode  <= mode;
                        r_state <= c_S_FILL;
                    end
                end
                c_S_FILL: begin
                    if (w_in_beat && w_fill_done) begin
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    if (w_in_beat && w_in_last) begin
                        r_state <= c_S_FLUSH;
                    end
                end
                default: begin
                    if (r_out_valid && r_out_last && out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    // Single output register plus the raster position of the centre it will carry next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_last  <= 1'b0;
            r_cen_col   <= '0;
            r_cen_row   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_pixel <= w_result;
            r_out_last  <= w_cen_last;
            if (r_cen_col == c_COL_LAST) begin
                r_cen_col <= '0;
                r_cen_row <= (r_cen_row == c_ROW_LAST) ? '0 : r_cen_row + c_ROW_ONE;
            end else begin
                r_cen_col <= r_cen_col + c_COL_ONE;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_last  = r_out_last;
    assign busy      = (r_state != c_S_IDLE) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_prewitt_stream_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_prewitt_stream_filter
//  Description : Self-checking bench for prewitt_stream_filter (4x5 frames).
//                A golden model computes each frame's results from the Prewitt
//                formulas; the results are queued when the frame is driven and
//                popped as output beats complete.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prewitt_stream_filter;

    localparam int R = 4;
    localparam int C = 5;
    localparam int N = R * C;

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pixel = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_pixel;
    logic       out_last;
    logic       busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   img [N];
    exp_t sb_q[$];
    bit   rdy_random = 1'b0;
    bit   in_random = 1'b0;
    bit   flush_chk = 1'b0;
    bit   was_stalled = 1'b0;
    logic [7:0] held_pix;
    logic       held_last;

    prewitt_stream_filter #(.PIX_W(8), .COLS(C), .ROWS(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Sink back-pressure
    always begin
        @(posedge clk);
        #1;
        out_ready = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    function automatic int px(int r, int c);
        return img[r * C + c];
    endfunction

    function automatic logic [7:0] golden(int m, int r, int c);
        int gx, gy, ax, ay, mag;
        if (r == 0 || r == R - 1 || c == 0 || c == C - 1) return 8'd0;
        gx = (px(r-1, c-1) + px(r, c-1) + px(r+1, c-1)) - (px(r-1, c+1) + px(r, c+1) + px(r+1, c+1));
        gy = (px(r-1, c-1) + px(r-1, c) + px(r-1, c+1)) - (px(r+1, c-1) + px(r+1, c) + px(r+1, c+1));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (m)
            0:       mag = ax;
            1:       mag = ay;
            2:       mag = ax + ay;
            default: mag = (ax > ay) ? ax : ay;
        endcase
        if (mag > 255) mag = 255;
        return mag[7:0];
    endfunction

    // Output monitor: scoreboard compare, stall stability, in_ready low during flush
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (was_stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pixel !== held_pix || out_last !== held_last) begin
                    n_errors++;
                    $display("FAIL stall_hold: valid=%0b pixel=%0d last=%0b, required valid=1 pixel=%0d last=%0b",
                             out_valid, out_pixel, out_last, held_pix, held_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: pixel=%0d last=%0b, required no output", out_pixel, out_last);
                end else begin
                    e = sb_q.pop_front();
                    if (out_pixel !== e.pix || out_last !== e.last) begin
                        n_errors++;
                        $display("FAIL out_beat: pixel=%0d last=%0b, required pixel=%0d last=%0b",
                                 out_pixel, out_last, e.pix, e.last);
                    end
                end
            end
            if (flush_chk) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL flush_in_ready: in_ready=%0b, required 0", in_ready);
                end
                if (out_valid === 1'b1 && out_ready === 1'b1 && out_last === 1'b1) flush_chk = 1'b0;
            end
            was_stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_pix    = out_pixel;
            held_last   = out_last;
        end else begin
            was_stalled = 1'b0;
        end
    end

    // Queue a frame's expected results, then feed n pixels of img
    task automatic drive_frame(input int m, input int n, input bit lat_chk);
        int cnt = 0;
        int tmo = 0;
        for (int k = 0; k < N; k++) begin
            sb_q.push_back('{pix: golden(m, k / C, k % C), last: (k == N - 1)});
        end
        while (cnt < n && tmo < 4000) begin
            @(posedge clk);
            #1;
            in_valid = in_random ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_pixel = img[cnt][7:0];
            mode_i   = (cnt == 0) ? m[1:0] : 2'($urandom_range(0, 3));
            @(negedge clk);
            if (lat_chk && cnt == C + 1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL latency_early: out_valid=%0b after %0d inputs, required 0", out_valid, cnt);
                end
            end
            if (lat_chk && cnt == C + 2) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL latency_first: out_valid=%0b after %0d inputs, required 1", out_valid, cnt);
                end
            end
            if (in_valid && in_ready === 1'b1) cnt++;
            tmo++;
        end
        if (cnt < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL input_timeout: accepted=%0d, required %0d", cnt, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (n == N) flush_chk = 1'b1;
    endtask

    // Wait for every queued result to emerge, then expect the block idle
    task automatic wait_drain(input string name);
        int tmo = 0;
        do begin
            @(negedge clk);
            tmo++;
        end while (!(sb_q.size() == 0 && out_valid === 1'b0) && tmo < 3000);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: outputs outstanding=%0d, required 0", name, sb_q.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_idle_busy: busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: valid=%0b pixel=%0d last=%0b busy=%0b in_ready=%0b, required 0 0 0 0 1",
                     name, out_valid, out_pixel, out_last, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_during");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_after");
    endtask

    task automatic test_constant();
        for (int k = 0; k < N; k++) img[k] = 77;
        drive_frame(2, N, 1'b1);
        wait_drain("constant");
    endtask

    task automatic test_vertical_step();
        for (int k = 0; k < N; k++) img[k] = ((k % C) >= 2) ? 50 : 0;
        drive_frame(0, N, 1'b0);
        wait_drain("vstep_gx");
        drive_frame(1, N, 1'b0);
        wait_drain("vstep_gy");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < N; k++) img[k] = ((k % C) >= 2) ? 200 : 0;
        drive_frame(0, N, 1'b0);
        wait_drain("saturate");
    endtask

    task automatic test_diagonal_ramp();
        for (int k = 0; k < N; k++) img[k] = 10 * ((k / C) + (k % C));
        drive_frame(2, N, 1'b0);
        wait_drain("ramp_sum");
        drive_frame(3, N, 1'b0);
        wait_drain("ramp_max");
    endtask

    task automatic test_random_handshake();
        rdy_random = 1'b1;
        in_random  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, 255));
            drive_frame(f, N, 1'b0);
        end
        wait_drain("random");
        rdy_random = 1'b0;
        in_random  = 1'b0;
    endtask

    task automatic test_abort_and_back_to_back();
        for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, 255));
        drive_frame(2, 9, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        flush_chk = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("abort_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("abort_idle");
        for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, 255));
        drive_frame(3, N, 1'b0);
        for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, 255));
        drive_frame(0, N, 1'b0);
        rdy_random = 1'b1;
        for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, 255));
        drive_frame(2, N, 1'b0);
        wait_drain("back_to_back");
        rdy_random = 1'b0;
    endtask

    initial begin
        test_reset();
        test_constant();
        test_vertical_step();
        test_saturation();
        test_diagonal_ramp();
        test_random_handshake();
        test_abort_and_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
